// File: rtl/mtm_chk_pkg.sv
// Shared types for the MTM ALU response checker.
// Verdict kinds and the default expected-entry layout.
package mtm_chk_pkg;

  localparam int CHK_DATA_W  = 32;
  localparam int CHK_FLAGS_W = 4;
  localparam int CHK_ERRF_W  = 3;

  typedef enum logic [2:0] {
    CHK_PASS       = 3'd0,
    CHK_FRAME_KIND = 3'd1,
    CHK_ERR_FLAGS  = 3'd2,
    CHK_FLAGS      = 3'd3,
    CHK_RESULT     = 3'd4,
    CHK_UNEXPECTED = 3'd5,
    CHK_TIMEOUT    = 3'd6
  } chk_kind_t;

  typedef struct packed {
    logic [CHK_DATA_W-1:0]  data;
    logic [CHK_FLAGS_W-1:0] flags;
    logic                   err;
    logic [CHK_ERRF_W-1:0]  errf;
  } exp_entry_t;

endpackage

// File: rtl/mtm_chk_fifo.sv
// Synchronous FIFO holding expected entries.
// Pointers carry an extra wrap bit to split full from empty.
module mtm_chk_fifo #(
  parameter int W     = $bits(mtm_chk_pkg::exp_entry_t),
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full)
        wptr <= wptr + (AW+1)'(1);
      if (pop && !empty)
        rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mtm_alu_resp_checker.sv
// In-order response checker: expected queue, verdicts, counters, timeout.
// Define MTM_CHK_FIRST_MISMATCH_EN to add first-mismatch capture ports.
module mtm_alu_resp_checker
  import mtm_chk_pkg::*;
#(
  parameter int DATA_W  = CHK_DATA_W,
  parameter int FLAGS_W = CHK_FLAGS_W,
  parameter int ERRF_W  = CHK_ERRF_W,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               exp_valid,
  output logic               exp_ready,
  input  logic [DATA_W-1:0]  exp_data,
  input  logic [FLAGS_W-1:0] exp_flags,
  input  logic               exp_err,
  input  logic [ERRF_W-1:0]  exp_errf,
  input  logic               act_valid,
  input  logic [DATA_W-1:0]  act_data,
  input  logic [FLAGS_W-1:0] act_flags,
  input  logic               act_err,
  input  logic [ERRF_W-1:0]  act_errf,
  output logic               cmp_valid,
  output chk_kind_t          cmp_kind,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic               q_overflow
`ifdef MTM_CHK_FIRST_MISMATCH_EN
  ,
  output logic               first_vld,
  output chk_kind_t          first_kind,
  output logic [DATA_W-1:0]  first_exp_data,
  output logic [DATA_W-1:0]  first_act_data,
  output logic [FLAGS_W+ERRF_W:0] first_exp_ctl,
  output logic [FLAGS_W+ERRF_W:0] first_act_ctl
`endif
);
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int ENT_W = DATA_W + FLAGS_W + 1 + ERRF_W;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [FLAGS_W-1:0] flags;
    logic               err;
    logic [ERRF_W-1:0]  errf;
  } ent_t;

  function automatic chk_kind_t classify(input ent_t e, input ent_t a);
    chk_kind_t k;
    k = CHK_PASS;
    if (a.err != e.err)
      k = CHK_FRAME_KIND;
    else if (e.err) begin
      if (a.errf != e.errf)
        k = CHK_ERR_FLAGS;
    end else if (a.flags != e.flags)
      k = CHK_FLAGS;
    else if (a.data != e.data)
      k = CHK_RESULT;
    return k;
  endfunction

  ent_t             exp_in;
  ent_t             act_in;
  ent_t             head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             bypass;
  logic             fire;
  logic [TMR_W-1:0] tmr;
  logic             nxt_valid;
  chk_kind_t        nxt_kind;
  ent_t             nxt_exp;
  ent_t             nxt_act;

  assign exp_in = '{data: exp_data, flags: exp_flags,
                    err: exp_err, errf: exp_errf};
  assign act_in = '{data: act_data, flags: act_flags,
                    err: act_err, errf: act_errf};

  assign exp_ready = !full;
  assign push      = exp_valid && !full;
  assign bypass    = act_valid && empty && push;
  assign fire      = (TIMEOUT != 0) && !empty && !act_valid &&
                     (tmr == TMR_W'(TIMEOUT - 1));
  assign pop       = (act_valid && !empty) || fire;

  mtm_chk_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push && !bypass),
    .pop   (pop),
    .din   (exp_in),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    nxt_valid = 1'b0;
    nxt_kind  = CHK_PASS;
    nxt_exp   = '0;
    nxt_act   = '0;
    if (act_valid) begin
      nxt_valid = 1'b1;
      nxt_act   = act_in;
      if (!empty) begin
        nxt_kind = classify(head, act_in);
        nxt_exp  = head;
      end else if (push) begin
        nxt_kind = classify(exp_in, act_in);
        nxt_exp  = exp_in;
      end else begin
        nxt_kind = CHK_UNEXPECTED;
      end
    end else if (fire) begin
      nxt_valid = 1'b1;
      nxt_kind  = CHK_TIMEOUT;
      nxt_exp   = head;
    end
  end

  // Wait time of the current head; restarts whenever the head changes.
  always_ff @(posedge clk) begin
    if (reset || empty || pop)
      tmr <= '0;
    else if (TIMEOUT != 0)
      tmr <= tmr + TMR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmp_valid <= 1'b0;
      cmp_kind  <= CHK_PASS;
    end else begin
      cmp_valid <= nxt_valid;
      cmp_kind  <= nxt_kind;
    end
  end

  // Counters follow the verdict pulse so a coincident clear drops it.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      frame_cnt  <= '0;
      err_cnt    <= '0;
      q_overflow <= 1'b0;
    end else begin
      if (cmp_valid && frame_cnt != '1)
        frame_cnt <= frame_cnt + CNT_W'(1);
      if (cmp_valid && cmp_kind != CHK_PASS && err_cnt != '1)
        err_cnt <= err_cnt + CNT_W'(1);
      if (exp_valid && full)
        q_overflow <= 1'b1;
    end
  end

`ifdef MTM_CHK_FIRST_MISMATCH_EN
  ent_t v_exp;
  ent_t v_act;

  always_ff @(posedge clk) begin
    if (reset) begin
      v_exp <= '0;
      v_act <= '0;
    end else begin
      v_exp <= nxt_exp;
      v_act <= nxt_act;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      first_vld      <= 1'b0;
      first_kind     <= CHK_PASS;
      first_exp_data <= '0;
      first_act_data <= '0;
      first_exp_ctl  <= '0;
      first_act_ctl  <= '0;
    end else if (cmp_valid && cmp_kind != CHK_PASS && !first_vld) begin
      first_vld      <= 1'b1;
      first_kind     <= cmp_kind;
      first_exp_data <= v_exp.data;
      first_act_data <= v_act.data;
      first_exp_ctl  <= {v_exp.err, v_exp.errf, v_exp.flags};
      first_act_ctl  <= {v_act.err, v_act.errf, v_act.flags};
    end
  end
`else
  logic unused_cap;
  assign unused_cap = ^{nxt_exp, nxt_act};
`endif

endmodule
